// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem read, IF/ID pipeline register,
// and the stall handshake back to the PC so it advances once per accepted word.
module fetch_stage #(
  parameter int                 ADDR_W  = 11,
  parameter int                 INSTR_W = 16,
  parameter logic [INSTR_W-1:0] NOP     = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               branch,
  input  logic               id_stall,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               stall_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               ifid_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   req_pc;
  logic [INSTR_W-1:0]  hold_buf;
  logic                accept;
  logic [INSTR_W-1:0]  load_instr;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    accept = 1'b0;
    case (state)
      WAIT:    accept = imem_valid & ~id_stall & ~branch;
      HOLD:    accept = ~id_stall & ~branch;
      default: accept = 1'b0;
    endcase
  end

  // A word parked in hold_buf is delivered from there; otherwise straight from memory.
  assign load_instr = (state == HOLD) ? hold_buf : imem_rdata;

  // Request and stall are combinational so a zero-wait memory reaches 1 instr / 2 cycles.
  assign imem_req  = ~reset & (state == FETCH) & ~branch;
  assign imem_addr = pc;
  assign stall_pc  = ~reset & ~(accept | branch);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      req_pc   <= '0;
      hold_buf <= NOP;
    end else begin
      case (state)
        FETCH: begin
          if (!branch) begin
            req_pc <= pc;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (branch) begin
            state <= imem_valid ? FETCH : DRAIN;
          end else if (imem_valid) begin
            if (id_stall) begin
              hold_buf <= imem_rdata;
              state    <= HOLD;
            end else begin
              state <= FETCH;
            end
          end
        end
        HOLD: begin
          if (branch || !id_stall) state <= FETCH;
        end
        DRAIN: begin
          // The flushed request's response must be consumed before issuing again.
          if (imem_valid) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP;
      ifid_pc    <= '0;
    end else if (branch) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP;
    end else if (id_stall) begin
      ifid_valid <= ifid_valid;
    end else if (accept) begin
      ifid_valid <= 1'b1;
      ifid_instr <= load_instr;
      ifid_pc    <= req_pc;
    end else begin
      ifid_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

- Instruction-fetch stage sitting directly downstream of `PC`.
- Takes the 11-bit `pc_out`, issues one read per instruction to instruction memory, and captures the returned 16-bit word plus its PC into the IF/ID pipeline register.
- Drives `stall` back into `PC` so the PC advances only when a fetched word has been accepted.
- Flushes in-flight work on `branch`.

## Interface
- `ADDR_W`, 11, PC / instruction-memory address width
- `INSTR_W`, 16, instruction width
- `NOP`, 16'h0000, value loaded into `ifid_instr` on reset or flush
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `pc`  in  ADDR_W  current PC (from `PC.pc_out`)
- `branch`  in  1  branch taken this cycle (same signal driven to `PC`); flushes stage
- `id_stall`  in  1  decode cannot accept; IF/ID register must hold
- `imem_rdata`  in  INSTR_W  memory read data, valid when `imem_valid`=1
- `imem_valid`  in  1  one-cycle response strobe; exactly one per request, ≥1 cycle after it
- `imem_req`  out  1  one-cycle read request pulse
- `imem_addr`  out  ADDR_W  read address, valid with `imem_req` (= `pc`)
- `stall_pc`  out  1  to `PC.stall`; 1 = PC holds
- `ifid_instr`  out  INSTR_W  IF/ID instruction
- `ifid_pc`  out  ADDR_W  PC of `ifid_instr`
- `ifid_valid`  out  1  IF/ID holds a real instruction

## Operation
- FSM states: FETCH, WAIT, HOLD, DRAIN.
- Reset state is FETCH.
- Internal regs: `req_pc` (ADDR_W) and `hold_buf` (INSTR_W).
- `accept`: the cycle a word enters IF/ID.
  - In WAIT: `imem_valid & ~id_stall & ~branch`.
  - In HOLD: `~id_stall & ~branch`.
- FETCH:
  - If `branch`=0: `imem_req`=1, `imem_addr`=`pc`, `req_pc`<=`pc`, go to WAIT.
  - If `branch`=1: no request; stay in FETCH.
- WAIT:
  - `branch` with `imem_valid`: discard the word, go to FETCH.
  - `branch` without `imem_valid`: go to DRAIN.
  - `imem_valid & ~id_stall`: load IF/ID with {`imem_rdata`, `req_pc`}, go to FETCH.
  - `imem_valid & id_stall`: `hold_buf`<=`imem_rdata`, go to HOLD.
  - Otherwise: stay in WAIT.
- HOLD:
  - `branch`: drop `hold_buf`, go to FETCH.
  - `~id_stall`: load IF/ID with {`hold_buf`, `req_pc`}, go to FETCH.
  - Otherwise: stay in HOLD.
- DRAIN: stay until `imem_valid`, discard that word, go to FETCH. A further `branch` keeps the state in DRAIN.
- `stall_pc` = `~(accept | branch)`, combinational.
  - The PC advances exactly once per accepted word.
  - The PC always takes a branch target.
- IF/ID update priority, highest first:
  1. reset
  2. `branch`: `ifid_valid`<=0, `ifid_instr`<=NOP
  3. `id_stall`: hold all fields
  4. `accept`: load, `ifid_valid`<=1
  5. else: `ifid_valid`<=0 (bubble; `instr`/`pc` unchanged)
- Reset behaviour:
  - State becomes FETCH; `ifid_valid`=0, `ifid_instr`=NOP, `ifid_pc`=0, `req_pc`=0.
  - `imem_req`=0 and `stall_pc`=0 while `reset`=1.
  - A memory response arriving after reset while in FETCH is ignored.

## Timing
- Request in cycle t; response earliest at t+1.
- Zero-wait memory: `imem_valid` at t+1, IF/ID valid from t+2, PC advances at the t+1 edge.
- Peak throughput: 1 instruction per 2 cycles.
- Memory latency of L cycles gives 1 instruction per L+1 cycles.
- `stall_pc` is high in FETCH and in WAIT-without-valid, so the PC never runs ahead of outstanding fetches.
- At most one request is outstanding; `imem_req` is never asserted in WAIT, HOLD or DRAIN.
- `branch` and `imem_valid` in the same WAIT cycle: the word is discarded, not loaded.
- `branch` and `id_stall` together: the flush wins and `ifid_valid` goes to 0.
- Reset mid-WAIT: the pending response is not tracked. The memory model must not return a response after reset.

## Test plan
- Reset, `pc`=0, memory latency 1 returning 16'hA000+addr:
  - `imem_req` pulses every 2nd cycle with addr 0, 1, 2.
  - IF/ID shows {A000, 0}, {A001, 1}, {A002, 2}, with `ifid_valid` alternating 1/0.
- Latency 3 at `pc`=5:
  - `stall_pc` stays high for 3 cycles.
  - One IF/ID load of {A005, 5}; the next request is addr 6.
- `id_stall` held 4 cycles across the response for `pc`=7:
  - State enters HOLD and `stall_pc` stays 1.
  - IF/ID holds its prior contents; `ifid_pc`=7 loads the cycle after `id_stall` drops.
- `branch` during WAIT (pc 3, target 9'h023), response arriving 2 cycles later:
  - State goes through DRAIN; `ifid_valid`=0.
  - The late word is discarded; the next request is addr 35.
- `branch` coincident with `imem_valid`: no load, `ifid_instr`=NOP, `ifid_valid`=0, next request is the target.
- `reset` asserted mid-HOLD: next cycle `ifid_valid`=0, `ifid_pc`=0, state FETCH; the first request after release is addr 0.
